// File: rtl/axi_mem_rd_responder.sv
// AXI read-only memory responder: AR -> LATENCY wait -> 64-bit R burst (FIXED/INCR/WRAP).
// Optional AXI_RSP_RANDOM_STALL_EN inserts LFSR-driven idle cycles between beats.
module axi_mem_rd_responder #(
   parameter int ADDR_WIDTH = 16,
   parameter int ID_WIDTH   = 4,
   parameter int LATENCY    = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ID_WIDTH-1:0]   arid_i,
   input  logic [31:0]           araddr_i,
   input  logic [3:0]            arlen_i,
   input  logic [2:0]            arsize_i,
   input  logic [1:0]            arburst_i,
   input  logic                  arvalid_i,
   output logic                  arready_o,
   output logic [ID_WIDTH-1:0]   rid_o,
   output logic [63:0]           rdata_o,
   output logic [1:0]            rresp_o,
   output logic                  rlast_o,
   output logic                  rvalid_o,
   input  logic                  rready_i,
   input  logic                  init_we_i,
   input  logic [ADDR_WIDTH-1:0] init_addr_i,
   input  logic [31:0]           init_wdata_i
);

   localparam int WW    = ADDR_WIDTH - 3;
   localparam int DEPTH = 1 << WW;

   typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [3:0]          beat_q, beat_d;
   logic [ID_WIDTH-1:0] id_q, id_d;
   logic [WW-1:0]       w0_q, w0_d;
   logic [3:0]          len_q, len_d;
   logic [1:0]          burst_q, burst_d;
   logic                err_q, err_d;
   logic                arready_q, arready_d;
   logic                rvalid_q, rvalid_d;
   logic                rlast_q, rlast_d;
   logic [63:0]         rdata_q, rdata_d;
   logic [ID_WIDTH-1:0] rid_q, rid_d;
   logic [1:0]          rresp_q, rresp_d;

   logic [63:0]         mem [DEPTH];
   logic [3:0]          ld_k;
   logic [WW-1:0]       ld_addr;
   logic [WW-1:0]       mask;
   logic [WW-1:0]       sum;
   logic [63:0]         ld_data;
   logic                ar_err;
   logic                unused;

   assign unused = ^{araddr_i[31:ADDR_WIDTH], araddr_i[2:0], init_addr_i[1:0]};

   always_ff @(posedge clk) begin
      if (init_we_i) begin
         if (init_addr_i[2])
            mem[init_addr_i[ADDR_WIDTH-1:3]][63:32] <= init_wdata_i;
         else
            mem[init_addr_i[ADDR_WIDTH-1:3]][31:0] <= init_wdata_i;
      end
   end

`ifdef AXI_RSP_RANDOM_STALL_EN
   logic [15:0] lfsr_q, lfsr_d;
   logic        stall_q, stall_d;
   logic        fb;

   assign fb     = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
   assign lfsr_d = (state_q == BURST) ? {lfsr_q[14:0], fb} : lfsr_q;
   // during a stall beat_q already points at the pending beat
   assign ld_k   = (state_q == BURST) ?
                   (stall_q ? beat_q : beat_q + 4'd1) : 4'd0;
`else
   assign ld_k   = (state_q == BURST) ? beat_q + 4'd1 : 4'd0;
`endif

   // WRAP: len is the wrap mask since len+1 is a power of two
   assign mask = WW'(len_q);
   assign sum  = w0_q + WW'(ld_k);

   always_comb begin
      ld_addr = w0_q;
      unique case (burst_q)
         2'b01:   ld_addr = sum;
         2'b10:   ld_addr = (w0_q & ~mask) | (sum & mask);
         default: ld_addr = w0_q;
      endcase
   end

   assign ld_data = err_q ? 64'd0 : mem[ld_addr];

   assign ar_err = (arsize_i != 3'b011) || (arburst_i == 2'b11) ||
                   ((arburst_i == 2'b10) && (arlen_i != 4'd1) &&
                    (arlen_i != 4'd3) && (arlen_i != 4'd7) &&
                    (arlen_i != 4'd15));

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      beat_d    = beat_q;
      id_d      = id_q;
      w0_d      = w0_q;
      len_d     = len_q;
      burst_d   = burst_q;
      err_d     = err_q;
      arready_d = arready_q;
      rvalid_d  = rvalid_q;
      rlast_d   = rlast_q;
      rdata_d   = rdata_q;
      rid_d     = rid_q;
      rresp_d   = rresp_q;
`ifdef AXI_RSP_RANDOM_STALL_EN
      stall_d   = stall_q;
`endif
      unique case (state_q)
         IDLE: begin
            arready_d = 1'b1;
            if (arvalid_i && arready_q) begin
               arready_d = 1'b0;
               state_d   = WAIT;
               cnt_d     = 4'(LATENCY - 1);
               id_d      = arid_i;
               w0_d      = araddr_i[ADDR_WIDTH-1:3];
               len_d     = arlen_i;
               burst_d   = arburst_i;
               err_d     = ar_err;
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d  = BURST;
               beat_d   = 4'd0;
               rvalid_d = 1'b1;
               rdata_d  = ld_data;
               rid_d    = id_q;
               rresp_d  = err_q ? 2'b10 : 2'b00;
               rlast_d  = (len_q == 4'd0);
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         BURST: begin
            if (rvalid_q && rready_i) begin
               if (rlast_q) begin
                  state_d   = IDLE;
                  rvalid_d  = 1'b0;
                  rlast_d   = 1'b0;
                  arready_d = 1'b1;
`ifdef AXI_RSP_RANDOM_STALL_EN
               end else if (lfsr_q[0]) begin
                  rvalid_d = 1'b0;
                  stall_d  = 1'b1;
                  beat_d   = beat_q + 4'd1;
`endif
               end else begin
                  beat_d  = ld_k;
                  rdata_d = ld_data;
                  rlast_d = (ld_k == len_q);
               end
`ifdef AXI_RSP_RANDOM_STALL_EN
            end else if (stall_q) begin
               stall_d  = 1'b0;
               rvalid_d = 1'b1;
               beat_d   = ld_k;
               rdata_d  = ld_data;
               rlast_d  = (ld_k == len_q);
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         beat_q    <= '0;
         id_q      <= '0;
         w0_q      <= '0;
         len_q     <= '0;
         burst_q   <= '0;
         err_q     <= 1'b0;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
         rdata_q   <= '0;
         rid_q     <= '0;
         rresp_q   <= '0;
`ifdef AXI_RSP_RANDOM_STALL_EN
         lfsr_q    <= 16'hACE1;
         stall_q   <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         beat_q    <= beat_d;
         id_q      <= id_d;
         w0_q      <= w0_d;
         len_q     <= len_d;
         burst_q   <= burst_d;
         err_q     <= err_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rlast_q   <= rlast_d;
         rdata_q   <= rdata_d;
         rid_q     <= rid_d;
         rresp_q   <= rresp_d;
`ifdef AXI_RSP_RANDOM_STALL_EN
         lfsr_q    <= lfsr_d;
         stall_q   <= stall_d;
`endif
      end
   end

   assign arready_o = arready_q;
   assign rvalid_o  = rvalid_q;
   assign rlast_o   = rlast_q;
   assign rdata_o   = rdata_q;
   assign rid_o     = rid_q;
   assign rresp_o   = rresp_q;

endmodule

// File: doc/axi_mem_rd_responder.md
# axi_mem_rd_responder

Synthesizable AXI read-only memory responder: accepts AR requests, returns 64-bit R bursts from an internal word array, including critical-word-first WRAP bursts. It is the responder end of the read path the cache controller's miss handler drives (mem AR/R channels). It replaces the behavioral memory slave in FPGA/emulation builds and serves as a reference target for protocol checking.

## Interface
- ADDR_WIDTH, 16, byte-address bits decoded; array holds 2^(ADDR_WIDTH-3) 64-bit words
- ID_WIDTH, 4, arid/rid width
- LATENCY, 4, cycles from AR handshake edge to first rvalid_o (legal 1..15)
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- arid_i  in  ID_WIDTH  request ID
- araddr_i  in  32  byte address; bits [31:ADDR_WIDTH] ignored
- arlen_i  in  4  beats-1
- arsize_i  in  3  beat size; only 3'b011 (8 B) supported
- arburst_i  in  2  00 FIXED, 01 INCR, 10 WRAP
- arvalid_i  in  1  request valid
- arready_o  out  1  request accept
- rid_o  out  ID_WIDTH  echoes accepted arid
- rdata_o  out  64  read data
- rresp_o  out  2  00 OKAY, 10 SLVERR
- rlast_o  out  1  final beat
- rvalid_o  out  1  data valid
- rready_i  in  1  data accept
- init_we_i  in  1  backdoor 32-bit word write
- init_addr_i  in  ADDR_WIDTH  byte address; [1:0] ignored
- init_wdata_i  in  32  write data; addr[2]=0 -> low half, 1 -> high half

## Operation
- FSM: IDLE (arready_o=1) -> WAIT (LATENCY countdown) -> BURST (beats) -> IDLE; one outstanding request only.
- Latched on AR handshake: id, word index w0=araddr[ADDR_WIDTH-1:3], len, burst, error flag.
- Beat k address: FIXED w0; INCR w0+k, wraps modulo array size; WRAP low log2(len+1) bits of w0 replaced by (w0+k) mod (len+1), upper bits held.
- Error (SLVERR on every beat, rdata_o=0, full len+1 beats, rlast on last): arsize≠3; burst=11; WRAP with arlen∉{1,3,7,15}.
- araddr[2:0]≠0 is not an error: treated as aligned down.
- Backdoor write: any state; takes effect at that edge; a beat whose data is captured the same edge returns old data.
- rdata_o/rid_o/rresp_o/rlast_o hold stable while rvalid_o=1 and rready_i=0.

## Timing
- Reset (rst_n=0 at an edge): arready_o=0, rvalid_o=0, rlast_o=0, rdata_o=0, rid_o=0, rresp_o=0, FSM IDLE, counters 0; arready_o=1 from first edge with rst_n=1. Array contents not reset.
- Reset mid-burst: burst aborted, rvalid_o=0 next cycle, no further beats.
- AR handshake at edge T: arready_o=0 from T; first rvalid_o=1 after edge T+LATENCY.
- Beats back-to-back: handshake at edge E, next beat valid after E (no bubble) while rready_i=1.
- rlast handshake at edge L: rvalid_o=0 and arready_o=1 after L; new AR accepted at L+1 earliest.
- arvalid_i while busy ignored (arready_o=0); no requirement that arvalid_i be held by spec, but bench holds it.

## Configuration
- AXI_RSP_RANDOM_STALL_EN defined: 16-bit LFSR (seed 16'hACE1, taps 16,14,13,11; reset reseeds) inserts one idle cycle (rvalid_o=0) before each non-first beat when LFSR[0]=1; LFSR advances every cycle in BURST. Beat order/data unchanged.
- Undefined: no stalls; timing exactly as above; LFSR absent.

## Test plan
- Fill word 0x0040 with pattern; AR araddr=0x0218, arlen=7, WRAP, size 3, id=5 -> 8 beats, word indices 0x43,44,45,46,47,40,41,42, rid=5, rresp=00, rlast only on beat 8, first rvalid LATENCY cycles after handshake.
- INCR arlen=3 at araddr=0xFFF8 (ADDR_WIDTH=16) -> words 0x1FFF,0x0000,0x0001,0x0002.
- rready_i toggling 1,0,0,1 each beat -> data/rlast stable during stalls, no lost or duplicated beat.
- arsize=2, arlen=3 -> 4 beats rresp=10, rdata=0; WRAP arlen=2 -> 3 beats SLVERR; arready returns next cycle.
- rst_n=0 for one cycle at beat 3 of 8 -> rvalid_o=0 next cycle, arready_o=1 after release, new request served correctly.
- Backdoor write to word being returned on same edge -> old data; subsequent read -> new data.
